etc_texel_writer: RTL and testbench

Downstream stage of the ETC image block fetcher. It takes one 64-bit compressed block plus a texel index (0–15) and block coordinates from the fetcher. It decodes that texel using ETC1 individual or differential mode and writes the RGB888 result into a 128x128 frame buffer. It then pulses `write_finish`, which advances the fetcher to the next texel.

---
 rtl/etc_pkg.sv | 44 ++++
 rtl/etc_texel_alu.sv | 21 ++
 rtl/etc_texel_writer.sv | 165 ++++++++++++++++
 tb/tb_etc_texel_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared definitions for the ETC texel writer.
//   - FSM state encoding
//   - bit-field positions inside the 64-bit ETC1 block word
//   - ETC1 intensity modifier table lookup
//   - error colour written when a non-ETC1 block is detected
package etc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam int DIFF_BIT = 33;
  localparam int FLIP_BIT = 32;
  localparam int TBL1_MSB = 39;
  localparam int TBL1_LSB = 37;
  localparam int TBL2_MSB = 36;
  localparam int TBL2_LSB = 34;

  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  // Index bit0 selects the large/small magnitude, bit1 selects negation.
  function automatic logic signed [8:0] etc_modifier(input logic [2:0] tbl,
                                                     input logic [1:0] idx);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mag;
    case (tbl)
      3'd0:    begin a = 8'd2;  b = 8'd8;   end
      3'd1:    begin a = 8'd5;  b = 8'd17;  end
      3'd2:    begin a = 8'd9;  b = 8'd29;  end
      3'd3:    begin a = 8'd13; b = 8'd42;  end
      3'd4:    begin a = 8'd18; b = 8'd60;  end
      3'd5:    begin a = 8'd24; b = 8'd80;  end
      3'd6:    begin a = 8'd33; b = 8'd106; end
      default: begin a = 8'd47; b = 8'd183; end
    endcase
    mag = idx[0] ? b : a;
    return idx[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

endpackage

// File: rtl/etc_texel_alu.sv
// One colour channel: 8-bit base plus signed modifier, clamped to 0..255.
//   base_i  in  8 : expanded base colour channel
//   off_i   in  9 : signed modifier (-183..+183)
//   res_o   out 8 : clamped channel value
module etc_texel_alu (
  input  logic              [7:0] base_i,
  input  logic signed       [8:0] off_i,
  output logic              [7:0] res_o
);

  // 10 bits covers -183..438 without wrap.
  logic signed [9:0] sum;
  assign sum = $signed({2'b00, base_i}) + $signed({off_i[8], off_i});

  always_comb begin
    res_o = sum[7:0];
    if (sum[9])      res_o = 8'h00;
    else if (sum[8]) res_o = 8'hFF;
  end

endmodule

// File: rtl/etc_texel_writer.sv
// ETC1 texel decoder and frame-buffer writer.
// Accepts one texel request (block + index + block coords), decodes it in
// individual or differential mode, issues one frame-buffer write, then
// pulses write_finish. Sequence: IDLE -> DECODE -> WRITE -> ACK -> IDLE.
// The first IDLE cycle after ACK ignores valid so a request the fetcher has
// not yet retired cannot be accepted twice.
//
// Ports:
//   sclk, rsrt_n        clock, synchronous active-low reset
//   valid               request pending
//   block_in[63:0]      compressed block
//   blockX_in/blockY_in block coordinates (low BLK_W_LOG2 bits used)
//   pixIdx_in[4:0]      texel index, bit 4 set = ignore request
//   write_finish        one-cycle pulse after the write
//   fb_we               one-cycle write strobe
//   fb_addr             {blockY, y, blockX, x}
//   fb_data             {R,G,B}
//   mode_err            block is not ETC1 (only with detection enabled)
//
// Build option: define ETC2_MODE_DETECT_EN to flag differential-mode
// channel overflow (T/H/planar blocks) with mode_err and magenta data.
module etc_texel_writer
  import etc_pkg::*;
#(
  parameter int BLK_W_LOG2 = 5,
  parameter int ADDR_W     = 2 * (BLK_W_LOG2 + 2)
) (
  input  logic              sclk,
  input  logic              rsrt_n,
  input  logic              valid,
  input  logic [63:0]       block_in,
  input  logic [7:0]        blockX_in,
  input  logic [7:0]        blockY_in,
  input  logic [4:0]        pixIdx_in,
  output logic              write_finish,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              mode_err
);

  state_e                  state_q;
  logic                    rearm_q;  // high in the IDLE cycle right after ACK
  logic [63:0]             blk_q;
  logic [BLK_W_LOG2-1:0]   bx_q, by_q;
  logic [3:0]              pix_q;
  logic                    we_q, fin_q, merr_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [23:0]             data_q;

  logic unused_bits;
  assign unused_bits = ^{blockX_in[7:BLK_W_LOG2], blockY_in[7:BLK_W_LOG2]};

  // ---- decode (combinational from latched request) ----
  logic [1:0]        px, py;
  logic              diff, sub2;
  logic [2:0]        tbl;
  logic [3:0]        k;
  logic [1:0]        idx;
  logic signed [8:0] off;
  logic [2:0][7:0]   base, rgb;
  logic [23:0]       data_d;
  logic              merr_d;
  logic [ADDR_W-1:0] addr_d;

  assign px   = pix_q[1:0];
  assign py   = pix_q[3:2];
  assign diff = blk_q[DIFF_BIT];
  assign sub2 = blk_q[FLIP_BIT] ? py[1] : px[1];
  assign tbl  = sub2 ? blk_q[TBL2_MSB:TBL2_LSB] : blk_q[TBL1_MSB:TBL1_LSB];
  assign k    = {px, py};  // x*4 + y
  assign idx  = {blk_q[{2'b01, k}], blk_q[{2'b00, k}]};
  assign off  = etc_modifier(tbl, idx);

`ifdef ETC2_MODE_DETECT_EN
  logic [2:0] ovf;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam int HI = 63 - 8 * g;
    logic [7:0] fld;
    logic [3:0] c4;
    logic [4:0] c1, c2, c5;
    logic [2:0] d;
    assign fld = blk_q[HI -: 8];
    assign c4  = sub2 ? fld[3:0] : fld[7:4];
    assign c1  = fld[7:3];
    assign d   = fld[2:0];
`ifdef ETC2_MODE_DETECT_EN
    logic signed [6:0] s;
    assign s      = $signed({2'b00, c1}) + $signed({{4{d[2]}}, d});
    assign c2     = s[4:0];
    assign ovf[g] = s[6] | s[5];
`else
    assign c2 = c1 + {{2{d[2]}}, d};  // wraps modulo 32
`endif
    assign c5      = sub2 ? c2 : c1;
    assign base[g] = diff ? {c5, c5[4:2]} : {c4, c4};
    etc_texel_alu u_alu (.base_i(base[g]), .off_i(off), .res_o(rgb[g]));
  end

`ifdef ETC2_MODE_DETECT_EN
  assign merr_d = diff & (|ovf);
  assign data_d = merr_d ? MAGENTA : {rgb[0], rgb[1], rgb[2]};
`else
  assign merr_d = 1'b0;
  assign data_d = {rgb[0], rgb[1], rgb[2]};
`endif

  assign addr_d = {by_q, py, bx_q, px};

  // ---- control FSM with registered outputs ----
  always_ff @(posedge sclk) begin
    if (!rsrt_n) begin
      state_q <= ST_IDLE;
      rearm_q <= 1'b0;
      blk_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      pix_q   <= '0;
      we_q    <= 1'b0;
      fin_q   <= 1'b0;
      merr_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rearm_q <= 1'b0;
          if (!rearm_q && valid && !pixIdx_in[4]) begin
            blk_q   <= block_in;
            bx_q    <= blockX_in[BLK_W_LOG2-1:0];
            by_q    <= blockY_in[BLK_W_LOG2-1:0];
            pix_q   <= pixIdx_in[3:0];
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          we_q    <= 1'b1;
          addr_q  <= addr_d;
          data_q  <= data_d;
          merr_q  <= merr_d;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          we_q    <= 1'b0;
          fin_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        default: begin
          fin_q   <= 1'b0;
          rearm_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fb_we        = we_q;
  assign write_finish = fin_q;
  assign fb_addr      = addr_q;
  assign fb_data      = data_q;
  assign mode_err     = merr_q;

endmodule

// File: tb/tb_etc_texel_writer.sv
// Self-checking bench for etc_texel_writer: directed literal cases followed
// by randomized requests, all outputs compared each cycle against a
// transaction-level model of the decoder and handshake.
module tb_etc_texel_writer;

  logic        sclk = 1'b0;
  logic        rsrt_n;
  logic        valid;
  logic [63:0] block_in;
  logic [7:0]  blockX_in, blockY_in;
  logic [4:0]  pixIdx_in;
  logic        write_finish, fb_we, mode_err;
  logic [13:0] fb_addr;
  logic [23:0] fb_data;

  etc_texel_writer dut (
    .sclk(sclk), .rsrt_n(rsrt_n), .valid(valid), .block_in(block_in),
    .blockX_in(blockX_in), .blockY_in(blockY_in), .pixIdx_in(pixIdx_in),
    .write_finish(write_finish), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .mode_err(mode_err)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference: decode one texel straight from the ETC1 rules ----
  function automatic logic [24:0] model_px(input logic [63:0] b, input int pix);
    int ta[8];
    int tb_[8];
    int x, y, k, tbl, idx, off, v, c, c1, d, s;
    bit sub2, ovf;
    logic [7:0]  byt;
    logic [23:0] rgb;
    bit merr;
    ta  = '{2, 5, 9, 13, 18, 24, 33, 47};
    tb_ = '{8, 17, 29, 42, 60, 80, 106, 183};
    x = pix % 4; y = pix / 4; k = x * 4 + y;
    sub2 = b[32] ? (y >= 2) : (x >= 2);
    tbl  = sub2 ? int'(b[36:34]) : int'(b[39:37]);
    idx  = 2 * int'(b[16 + k]) + int'(b[k]);
    off  = (idx % 2 == 1) ? tb_[tbl] : ta[tbl];
    if (idx >= 2) off = -off;
    ovf = 0;
    rgb = '0;
    for (int ch = 0; ch < 3; ch++) begin
      byt = b[63 - 8 * ch -: 8];
      if (b[33]) begin
        c1 = int'(byt[7:3]);
        d  = int'(byt[2:0]);
        if (d > 3) d = d - 8;
        s = c1 + d;
        if (s < 0 || s > 31) ovf = 1;
        c = sub2 ? (s + 32) % 32 : c1;
        v = c * 8 + c / 4;
      end else begin
        c = sub2 ? int'(byt[3:0]) : int'(byt[7:4]);
        v = c * 17;
      end
      v = v + off;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      rgb[23 - 8 * ch -: 8] = v[7:0];
    end
    merr = 0;
`ifdef ETC2_MODE_DETECT_EN
    if (b[33] && ovf) begin
      merr = 1;
      rgb  = 24'hFF00FF;
    end
`endif
    return {merr, rgb};
  endfunction

  function automatic logic [13:0] model_addr(input int bx, input int by, input int pix);
    int row, col;
    row = (by % 32) * 4 + pix / 4;
    col = (bx % 32) * 4 + pix % 4;
    return 14'(row * 128 + col);
  endfunction

  // ---- transaction-level handshake model ----
  int          cyc = 0, ready_at = 0, we_cyc = 0;
  bit          live = 0, pend = 0;
  logic [23:0] pend_data, held_data;
  logic [13:0] pend_addr, held_addr;
  logic        pend_merr, held_merr;
  logic        exp_we, exp_fin;

  always @(posedge sclk) begin
    logic [24:0] r;
    int c;
    c = cyc;
    if (!rsrt_n) begin
      live = 1; pend = 0; ready_at = c + 1;
      held_data = '0; held_addr = '0; held_merr = 1'b0;
      exp_we = 1'b0; exp_fin = 1'b0;
    end else begin
      if (c >= ready_at && valid && !pixIdx_in[4]) begin
        r = model_px(block_in, int'(pixIdx_in));
        pend = 1; pend_merr = r[24]; pend_data = r[23:0];
        pend_addr = model_addr(int'(blockX_in), int'(blockY_in), int'(pixIdx_in));
        we_cyc = c + 2; ready_at = c + 5;
      end
      exp_we  = pend && (c + 1 == we_cyc);
      exp_fin = pend && (c + 1 == we_cyc + 1);
      if (exp_we) begin
        held_data = pend_data; held_addr = pend_addr; held_merr = pend_merr;
      end
      if (exp_fin) pend = 0;
    end
    cyc = c + 1;
  end

  always @(negedge sclk) begin
    if (live) begin
      chk("fb_we", fb_we, exp_we);
      chk("write_finish", write_finish, exp_fin);
      chk("fb_addr", fb_addr, held_addr);
      chk("fb_data", fb_data, held_data);
      chk("mode_err", mode_err, held_merr);
    end
  end

  // ---- directed transaction: one request, measure latency, capture write ----
  task automatic xact(input logic [63:0] b, input logic [7:0] bx, input logic [7:0] by,
                      input logic [4:0] pix, output logic [23:0] d, output logic [13:0] a,
                      output logic me);
    int lat;
    @(posedge sclk); #1;
    block_in = b; blockX_in = bx; blockY_in = by; pixIdx_in = pix; valid = 1'b1;
    @(posedge sclk); #1;
    valid = 1'b0;
    lat = -1; d = 'x; a = 'x; me = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge sclk);
      if (fb_we === 1'b1) begin
        lat = i + 1; d = fb_data; a = fb_addr; me = mode_err;
        break;
      end
    end
    chk("we_latency", 64'(lat), 64'd2);
    @(negedge sclk);
    chk("finish_after_we", write_finish, 1'b1);
    repeat (3) @(posedge sclk);
  endtask

  initial begin
    logic [23:0] d;
    logic [13:0] a;
    logic        me;
    int          nwe, nfin;

    rsrt_n = 1'b0; valid = 1'b0; block_in = '0;
    blockX_in = '0; blockY_in = '0; pixIdx_in = '0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_fb_data", fb_data, 24'h0);
    chk("rst_fb_we", fb_we, 1'b0);
    @(posedge sclk); #1;
    rsrt_n = 1'b1;

    xact(64'h888888_00_00000000, 8'd0, 8'd0, 5'd0, d, a, me);
    chk("indiv_p0", d, 24'h8A8A8A);
    xact(64'h888888_00_00000000, 8'd0, 8'd0, 5'd2, d, a, me);
    chk("indiv_p2", d, 24'h8A8A8A);
    chk("indiv_p2_addr", a, 14'd2);
    xact(64'hF0F0F0E0_00000001, 8'd0, 8'd0, 5'd0, d, a, me);
    chk("clamp_hi", d, 24'hFFFFFF);
    xact(64'hF0F0F0E0_00010001, 8'd0, 8'd0, 5'd0, d, a, me);
    chk("neg_b", d, 24'h484848);
    xact(64'h830000_02_00000000, 8'd0, 8'd0, 5'd0, d, a, me);
    chk("diff_p0", d, 24'h860202);
    xact(64'h830000_02_00000000, 8'd0, 8'd0, 5'd3, d, a, me);
    chk("diff_p3", d, 24'h9E0202);
    xact(64'hF90000_02_00000000, 8'd0, 8'd0, 5'd3, d, a, me);
`ifdef ETC2_MODE_DETECT_EN
    chk("ovf_data", d, 24'hFF00FF);
    chk("ovf_err", me, 1'b1);
`else
    chk("ovf_data", d, 24'h020202);
    chk("ovf_err", me, 1'b0);
`endif
    xact(64'h888888_00_00000000, 8'd3, 8'd5, 5'd6, d, a, me);
    chk("addr_3_5_6", a, 14'd2702);

    // valid held high for 15 cycles: accepts at cycles 0, 5, 10
    @(posedge sclk); #1;
    block_in = 64'h830000_02_00000000; pixIdx_in = 5'd5; valid = 1'b1;
    nwe = 0; nfin = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge sclk);
      nwe += int'(fb_we); nfin += int'(write_finish);
      @(posedge sclk); #1;
      if (i == 14) valid = 1'b0;
    end
    chk("held_valid_writes", 64'(nwe), 64'd3);
    chk("held_valid_acks", 64'(nfin), 64'd3);

    // invalid index: ignored
    pixIdx_in = 5'd16; valid = 1'b1;
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk);
      nwe += int'(fb_we) + int'(write_finish);
    end
    chk("pix16_ignored", 64'(nwe), 64'd0);
    @(posedge sclk); #1;
    valid = 1'b0;
    repeat (2) @(posedge sclk);

    // reset during DECODE drops the texel and clears outputs
    #1;
    block_in = 64'h888888_00_00000000; pixIdx_in = 5'd6; valid = 1'b1;
    @(posedge sclk); #1;
    valid = 1'b0; rsrt_n = 1'b0;
    @(posedge sclk); #1;
    rsrt_n = 1'b1;
    @(negedge sclk);
    chk("rst_mid_data", fb_data, 24'h0);
    chk("rst_mid_addr", fb_addr, 14'h0);
    nwe = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sclk);
      nwe += int'(fb_we) + int'(write_finish);
    end
    chk("rst_mid_dropped", 64'(nwe), 64'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(posedge sclk); #1;
      valid     = ($urandom_range(0, 3) != 0);
      block_in  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) block_in[33] = 1'b1;
      blockX_in = 8'($urandom);
      blockY_in = 8'($urandom);
      pixIdx_in = 5'($urandom_range(0, 19));
      rsrt_n    = ($urandom_range(0, 99) != 0);
    end
    @(posedge sclk); #1;
    valid = 1'b0; rsrt_n = 1'b1;
    repeat (8) @(posedge sclk);
    @(negedge sclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
